// File: rtl/sdram_phy_if.sv
// -----------------------------------------------------------------------------
// sdram_phy_if -- pin-level SDRAM PHY
//
// Registers every SDRAM command, address, mask and data pin one clk after the
// controller presents it. It owns the DQ tristate and captures read beats
// CAS_LATENCY + RD_EXTRA_DLY cycles after a READ leaves the pins. The captured
// beat is returned with rd_valid on the following cycle.
//
// Optional feature macro: SDRAM_PHY_CONFLICT_CHECK_EN
//   defined   : a wr_en that lands on an expected read beat pulses
//               bus_conflict, drops that beat's rd_valid, and raises a
//               simulation $error.
//   undefined : bus_conflict is tied low and no beat is suppressed.
//
// Ports
//   clk, rst                synchronous active-high reset, single clock domain
//   cmd_valid               command present (low -> NOP on pins)
//   cmd_cs_n, cmd_rcw_n     chip select and {ras_n,cas_n,we_n}
//   cmd_ba, cmd_addr        bank / address (held on NOP)
//   cke_in                  clock enable request
//   wr_en, wr_data, wr_dqm  write beat for the next pin cycle
//   rd_valid, rd_data       captured read beat
//   bus_conflict            write overlapped an expected read beat
//   sdram_*                 registered board pins; sdram_clk = ~clk
//   sdram_dq                bidirectional data, driven only while oe_q = 1
// -----------------------------------------------------------------------------

`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
// Simulation-only watcher that reports each DQ bus conflict.
module sdram_phy_if_conflict_chk (
  input logic clk,
  input logic rst,
  input logic bus_conflict
);
  // Flag every cycle in which the PHY reports a write/read overlap.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!bus_conflict) else $error("sdram_phy_if: wr_en overlapped an expected read beat");
    end
  end
endmodule
`endif

module sdram_phy_if #(
  parameter int unsigned ADDR_BITS    = 13,
  parameter int unsigned BA_BITS      = 2,
  parameter int unsigned DQ_BITS      = 16,
  parameter int unsigned DQM_BITS     = DQ_BITS / 8,
  parameter int unsigned CAS_LATENCY  = 2,
  parameter int unsigned BURST_LEN    = 1,
  parameter int unsigned RD_EXTRA_DLY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic                 cmd_cs_n,
  input  logic [2:0]           cmd_rcw_n,
  input  logic [BA_BITS-1:0]   cmd_ba,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 cke_in,
  input  logic                 wr_en,
  input  logic [DQ_BITS-1:0]   wr_data,
  input  logic [DQM_BITS-1:0]  wr_dqm,
  output logic                 rd_valid,
  output logic [DQ_BITS-1:0]   rd_data,
  output logic                 bus_conflict,
  output logic                 sdram_clk,
  output logic                 sdram_cke,
  output logic                 sdram_cs_n,
  output logic                 sdram_ras_n,
  output logic                 sdram_cas_n,
  output logic                 sdram_we_n,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [DQM_BITS-1:0]  sdram_dqm,
  inout  wire  [DQ_BITS-1:0]   sdram_dq
);

  // Tracker bit 0 means "sample DQ at the end of this cycle"; bit RD_EXTRA_DLY
  // means "a read beat is on the SDRAM pins this cycle".
  localparam int unsigned TRK_LEN   = CAS_LATENCY + RD_EXTRA_DLY + BURST_LEN;
  localparam int unsigned FIRST_BIT = CAS_LATENCY + RD_EXTRA_DLY - 1;

  // Bits loaded when a READ is seen on the pins: the mask is loaded one edge
  // after the pin cycle, so the first beat sits FIRST_BIT places from bit 0.
  function automatic logic [TRK_LEN-1:0] read_mask();
    logic [TRK_LEN-1:0] m;
    m = {TRK_LEN{1'b0}};
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      m[FIRST_BIT + i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [TRK_LEN-1:0] READ_MASK = read_mask();

`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
  localparam logic [TRK_LEN-1:0] PIN_BIT = {{(TRK_LEN-1){1'b0}}, 1'b1} << RD_EXTRA_DLY;
`endif

  logic                 cke_q, cke_d;
  logic                 cs_n_q, cs_n_d;
  logic [2:0]           rcw_q, rcw_d;
  logic [BA_BITS-1:0]   ba_q, ba_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DQM_BITS-1:0]  dqm_q, dqm_d;
  logic                 oe_q, oe_d;
  logic [DQ_BITS-1:0]   dq_out_q, dq_out_d;
  logic [TRK_LEN-1:0]   trk_q, trk_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DQ_BITS-1:0]   rd_data_q, rd_data_d;
  logic                 conflict_q, conflict_d;

  logic                 rd_on_pins;
  logic [TRK_LEN-1:0]   trk_pre;
  logic                 beat_next;

  // Next-state for pin registers, read tracker and capture path.
  always_comb begin
    rd_on_pins = !cs_n_q && (rcw_q == 3'b101);

    cke_d  = cke_in;
    cs_n_d = cmd_valid ? cmd_cs_n  : 1'b0;
    rcw_d  = cmd_valid ? cmd_rcw_n : 3'b111;
    ba_d   = cmd_valid ? cmd_ba    : ba_q;
    addr_d = cmd_valid ? cmd_addr  : addr_q;

    // Overlapping READs OR their masks so a later burst extends the stream.
    trk_pre   = {1'b0, trk_q[TRK_LEN-1:1]} | (rd_on_pins ? READ_MASK : {TRK_LEN{1'b0}});
    beat_next = trk_pre[RD_EXTRA_DLY];

    oe_d     = wr_en;
    dq_out_d = wr_data;
    dqm_d    = wr_en ? wr_dqm : (beat_next ? {DQM_BITS{1'b0}} : {DQM_BITS{1'b1}});

`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
    // Write wins the bus; the clobbered beat is removed before it is sampled.
    conflict_d = wr_en && beat_next;
    trk_d      = trk_pre & ~(conflict_d ? PIN_BIT : {TRK_LEN{1'b0}});
`else
    conflict_d = 1'b0;
    trk_d      = trk_pre;
`endif

    rd_valid_d = trk_q[0];
    rd_data_d  = trk_q[0] ? sdram_dq : rd_data_q;
  end

  // State registers with synchronous reset to the idle/deselected pin state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cke_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      rcw_q      <= 3'b111;
      ba_q       <= {BA_BITS{1'b0}};
      addr_q     <= {ADDR_BITS{1'b0}};
      dqm_q      <= {DQM_BITS{1'b1}};
      oe_q       <= 1'b0;
      dq_out_q   <= {DQ_BITS{1'b0}};
      trk_q      <= {TRK_LEN{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DQ_BITS{1'b0}};
      conflict_q <= 1'b0;
    end else begin
      cke_q      <= cke_d;
      cs_n_q     <= cs_n_d;
      rcw_q      <= rcw_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      dqm_q      <= dqm_d;
      oe_q       <= oe_d;
      dq_out_q   <= dq_out_d;
      trk_q      <= trk_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign sdram_clk    = ~clk;
  assign sdram_cke    = cke_q;
  assign sdram_cs_n   = cs_n_q;
  assign sdram_ras_n  = rcw_q[2];
  assign sdram_cas_n  = rcw_q[1];
  assign sdram_we_n   = rcw_q[0];
  assign sdram_ba     = ba_q;
  assign sdram_addr   = addr_q;
  assign sdram_dqm    = dqm_q;
  assign sdram_dq     = oe_q ? dq_out_q : {DQ_BITS{1'bz}};
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign bus_conflict = conflict_q;

`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
  sdram_phy_if_conflict_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .bus_conflict (conflict_q)
  );
`endif

endmodule

// File: tb/tb_sdram_phy_if.sv
// Testbench for sdram_phy_if: instance a uses the default BL=1, instance b
// uses BL=4; both share the command inputs and a board-side DQ driver.
module tb_sdram_phy_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_cs_n, cke_in, wr_en;
  logic [2:0]  cmd_rcw_n;
  logic [1:0]  cmd_ba, wr_dqm;
  logic [12:0] cmd_addr;
  logic [15:0] wr_data;
  logic        brd_en;
  logic [15:0] brd_val;

  wire  [15:0] dq_a, dq_b;
  assign dq_a = brd_en ? brd_val : 16'hzzzz;
  assign dq_b = brd_en ? brd_val : 16'hzzzz;

  logic        a_rv, a_bc, a_clk, a_cke, a_cs_n, a_ras, a_cas, a_we;
  logic [15:0] a_rd;
  logic [1:0]  a_ba, a_dqm;
  logic [12:0] a_addr;
  logic        b_rv, b_bc, b_clk, b_cke, b_cs_n, b_ras, b_cas, b_we;
  logic [15:0] b_rd;
  logic [1:0]  b_ba, b_dqm;
  logic [12:0] b_addr;

  always #5 clk = ~clk;

  sdram_phy_if dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_cs_n(cmd_cs_n), .cmd_rcw_n(cmd_rcw_n),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .cke_in(cke_in), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dqm(wr_dqm), .rd_valid(a_rv), .rd_data(a_rd), .bus_conflict(a_bc), .sdram_clk(a_clk),
    .sdram_cke(a_cke), .sdram_cs_n(a_cs_n), .sdram_ras_n(a_ras), .sdram_cas_n(a_cas),
    .sdram_we_n(a_we), .sdram_ba(a_ba), .sdram_addr(a_addr), .sdram_dqm(a_dqm), .sdram_dq(dq_a)
  );

  sdram_phy_if #(.BURST_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_cs_n(cmd_cs_n), .cmd_rcw_n(cmd_rcw_n),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .cke_in(cke_in), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dqm(wr_dqm), .rd_valid(b_rv), .rd_data(b_rd), .bus_conflict(b_bc), .sdram_clk(b_clk),
    .sdram_cke(b_cke), .sdram_cs_n(b_cs_n), .sdram_ras_n(b_ras), .sdram_cas_n(b_cas),
    .sdram_we_n(b_we), .sdram_ba(b_ba), .sdram_addr(b_addr), .sdram_dqm(b_dqm), .sdram_dq(dq_b)
  );

  typedef struct {
    logic        cv;
    logic        csn;
    logic [2:0]  rcw;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        cke;
    logic        we;
    logic [15:0] wd;
    logic [1:0]  wm;
    logic        e_csn;
    logic [2:0]  e_rcw;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    logic        e_cke;
    logic [1:0]  e_dqm;
    logic        e_oe;
    logic [15:0] e_dq;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;
  logic rv_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic cv, input logic csn, input logic [2:0] rcw,
                           input logic [1:0] ba, input logic [12:0] addr);
    cmd_valid = cv;
    cmd_cs_n  = csn;
    cmd_rcw_n = rcw;
    cmd_ba    = ba;
    cmd_addr  = addr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 3'b000, 2'd0, 13'h0000, 1'b1, 1'b0, 16'h0000, 2'b00,
                1'b0, 3'b111, 2'd0, 13'h0000, 1'b1, 2'b11, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 3'b011, 2'd2, 13'h1ABC, 1'b1, 1'b0, 16'h0000, 2'b00,
                1'b0, 3'b011, 2'd2, 13'h1ABC, 1'b1, 2'b11, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 3'b101, 2'd1, 13'h0055, 1'b1, 1'b0, 16'h0000, 2'b00,
                1'b0, 3'b111, 2'd2, 13'h1ABC, 1'b1, 2'b11, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 3'b101, 2'd3, 13'h0400, 1'b1, 1'b0, 16'h0000, 2'b00,
                1'b1, 3'b101, 2'd3, 13'h0400, 1'b1, 2'b11, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 3'b100, 2'd1, 13'h0010, 1'b1, 1'b1, 16'hBEEF, 2'b10,
                1'b0, 3'b100, 2'd1, 13'h0010, 1'b1, 2'b10, 1'b1, 16'hBEEF};
    vecs[5] = '{1'b0, 1'b0, 3'b000, 2'd0, 13'h0000, 1'b0, 1'b0, 16'h0000, 2'b00,
                1'b0, 3'b111, 2'd1, 13'h0010, 1'b0, 2'b11, 1'b0, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 3'b010, 2'd0, 13'h0400, 1'b1, 1'b0, 16'h0000, 2'b00,
                1'b0, 3'b010, 2'd0, 13'h0400, 1'b1, 2'b11, 1'b0, 16'h0000};

    rst = 1'b1;
    drive_cmd(1'b0, 1'b0, 3'b111, 2'd0, 13'h0000);
    cke_in = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; wr_dqm = 2'b00;
    brd_en = 1'b0; brd_val = 16'h0000;

    // reset held 3 clk
    repeat (3) step();
    chk("rst_cs_n", {31'd0, a_cs_n}, 32'd1);
    chk("rst_cke", {31'd0, a_cke}, 32'd0);
    chk("rst_rcw", {29'd0, a_ras, a_cas, a_we}, 32'd7);
    chk("rst_ba_addr", {17'd0, a_ba, a_addr}, 32'd0);
    chk("rst_dqm", {30'd0, a_dqm}, 32'd3);
    chk("rst_rd_valid", {31'd0, a_rv}, 32'd0);
    chk("rst_rd_data", {16'd0, a_rd}, 32'd0);
    chk("rst_bus_conflict", {31'd0, a_bc}, 32'd0);
    chk("sdram_clk_inv", {31'd0, a_clk}, 32'd0);
    brd_val = 16'h5A5A; brd_en = 1'b1;
    #1;
    chk("rst_dq_released", {16'd0, dq_a}, 32'h5A5A);
    brd_en = 1'b0;
    rst = 1'b0;

    // command / write path table
    rv_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_cmd(vecs[i].cv, vecs[i].csn, vecs[i].rcw, vecs[i].ba, vecs[i].addr);
      cke_in = vecs[i].cke; wr_en = vecs[i].we; wr_data = vecs[i].wd; wr_dqm = vecs[i].wm;
      step();
      rv_seen = rv_seen | a_rv | b_rv;
      chk($sformatf("vec%0d_cs_n", i), {31'd0, a_cs_n}, {31'd0, vecs[i].e_csn});
      chk($sformatf("vec%0d_rcw", i), {29'd0, a_ras, a_cas, a_we}, {29'd0, vecs[i].e_rcw});
      chk($sformatf("vec%0d_ba", i), {30'd0, a_ba}, {30'd0, vecs[i].e_ba});
      chk($sformatf("vec%0d_addr", i), {19'd0, a_addr}, {19'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d_cke", i), {31'd0, a_cke}, {31'd0, vecs[i].e_cke});
      chk($sformatf("vec%0d_dqm", i), {30'd0, a_dqm}, {30'd0, vecs[i].e_dqm});
      if (vecs[i].e_oe) begin
        chk($sformatf("vec%0d_dq", i), {16'd0, dq_a}, {16'd0, vecs[i].e_dq});
      end
    end
    drive_cmd(1'b0, 1'b0, 3'b111, 2'd0, 13'h0000);
    wr_en = 1'b0; cke_in = 1'b1;
    repeat (8) begin
      step();
      rv_seen = rv_seen | a_rv | b_rv;
    end
    chk("deselect_not_read", {31'd0, rv_seen}, 32'd0);

    // single READ, BL=1: rd_valid 5 clk after cmd
    drive_cmd(1'b1, 1'b0, 3'b101, 2'd1, 13'h0020);
    step();                                   // E0
    cmd_valid = 1'b0;
    step(); chk("rd1_e1_rv", {31'd0, a_rv}, 32'd0);
    chk("rd1_e1_dqm", {30'd0, a_dqm}, 32'd3);
    step(); chk("rd1_e2_rv", {31'd0, a_rv}, 32'd0);
    chk("rd1_beat_dqm", {30'd0, a_dqm}, 32'd0);
    brd_val = 16'h1111; brd_en = 1'b1;
    step(); chk("rd1_e3_rv", {31'd0, a_rv}, 32'd0);
    brd_val = 16'hA5C3;
    step(); chk("rd1_e4_rv", {31'd0, a_rv}, 32'd1);
    chk("rd1_e4_data", {16'd0, a_rd}, 32'hA5C3);
    brd_val = 16'h2222;
    step(); chk("rd1_e5_rv", {31'd0, a_rv}, 32'd0);
    chk("rd1_e5_hold", {16'd0, a_rd}, 32'hA5C3);
    brd_en = 1'b0;
    repeat (6) step();

    // READ, READ two cycles later: b gives 6 gapless beats, a gives 2
    for (int k = 0; k < 12; k++) begin
      if (k == 0 || k == 2) begin
        drive_cmd(1'b1, 1'b0, 3'b101, 2'd0, 13'h0040);
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      brd_val = 16'hB000 + 16'(k); brd_en = 1'b1;
      chk($sformatf("bl4_e%0d_b_rv", k), {31'd0, b_rv}, {31'd0, (k >= 4 && k <= 9)});
      if (k >= 4 && k <= 9) begin
        chk($sformatf("bl4_e%0d_b_data", k), {16'd0, b_rd}, {16'd0, 16'hB000 + 16'(k - 1)});
      end
      chk($sformatf("bl4_e%0d_a_rv", k), {31'd0, a_rv}, {31'd0, (k == 4 || k == 6)});
      if (k == 4 || k == 6) begin
        chk($sformatf("bl4_e%0d_a_data", k), {16'd0, a_rd}, {16'd0, 16'hB000 + 16'(k - 1)});
      end
    end
    brd_en = 1'b0;
    repeat (6) step();

    // WRITE: data and mask on pins next cycle, released the cycle after
    drive_cmd(1'b1, 1'b0, 3'b100, 2'd2, 13'h0008);
    wr_en = 1'b1; wr_data = 16'h1234; wr_dqm = 2'b01;
    step();
    chk("wr_rcw", {29'd0, a_ras, a_cas, a_we}, 32'd4);
    chk("wr_dq", {16'd0, dq_a}, 32'h1234);
    chk("wr_dqm", {30'd0, a_dqm}, 32'd1);
    cmd_valid = 1'b0; wr_en = 1'b0;
    step();
    chk("wr_after_dqm", {30'd0, a_dqm}, 32'd3);
    brd_val = 16'h5A5A; brd_en = 1'b1;
    #1;
    chk("wr_after_dq_released", {16'd0, dq_a}, 32'h5A5A);
    brd_en = 1'b0;
    repeat (4) step();

    // wr_en landing on an expected read beat
    drive_cmd(1'b1, 1'b0, 3'b101, 2'd0, 13'h0000);
    step();                                   // E0
    cmd_valid = 1'b0;
    step();                                   // E1
    drive_cmd(1'b1, 1'b0, 3'b100, 2'd0, 13'h0000);
    wr_en = 1'b1; wr_data = 16'h0F0F; wr_dqm = 2'b00;
    step();                                   // E2: write on the beat cycle
`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
    chk("conflict_pulse", {31'd0, a_bc}, 32'd1);
`else
    chk("conflict_tied0", {31'd0, a_bc}, 32'd0);
`endif
    chk("conflict_dq_write_wins", {16'd0, dq_a}, 32'h0F0F);
    cmd_valid = 1'b0; wr_en = 1'b0;
    step();
    chk("conflict_e3_bc", {31'd0, a_bc}, 32'd0);
    step();
`ifdef SDRAM_PHY_CONFLICT_CHECK_EN
    chk("conflict_rv_suppressed", {31'd0, a_rv}, 32'd0);
`else
    chk("conflict_rv_flagged", {31'd0, a_rv}, 32'd1);
`endif
    step();
    chk("conflict_e5_rv", {31'd0, a_rv}, 32'd0);
    repeat (6) step();

    // reset one cycle after READ issue drops the read
    drive_cmd(1'b1, 1'b0, 3'b101, 2'd0, 13'h0000);
    step();
    cmd_valid = 1'b0; rst = 1'b1;
    step();
    chk("midrd_rst_cs_n", {31'd0, a_cs_n}, 32'd1);
    rst = 1'b0;
    rv_seen = 1'b0;
    repeat (10) begin
      step();
      rv_seen = rv_seen | a_rv | b_rv;
    end
    chk("midrd_no_rv", {31'd0, rv_seen}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
